tpu_matmul_sequencer: RTL and testbench

Command-driven controller that sequences one 32×32 matrix multiply on `TOP_tpu`. It replaces the hand-timed stimulus currently needed to run the array. For each accepted command it:
- pulls one weight tile from the weight FIFO and latches it into the array;
- streams MATRIX_SIZE activation rows from the input SRAM;
- waits for the array's `end_`;
- walks the result SRAM, flagging each returned row.

It sits between a host/DMA command interface and the `TOP_tpu` control pins.

---
 rtl/tpu_matmul_sequencer_if.sv | 34 +++
 rtl/tpu_matmul_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_tpu_matmul_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_matmul_sequencer_if.sv
// Signal bundle between the matmul sequencer and its host, weight FIFO, SRAMs and TOP_tpu.
// master = host/array side (drives commands, FIFO flag, end_), slave = sequencer.
interface tpu_matmul_sequencer_if #(
    parameter int ADDRESSSIZE = 10
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDRESSSIZE-1:0] cmd_in_base;
    logic [ADDRESSSIZE-1:0] cmd_res_base;
    logic                   fifo_empty;
    logic                   start;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic                   valid_address;
    logic [ADDRESSSIZE-1:0] sram_address;
    logic                   end_;
    logic [ADDRESSSIZE-1:0] sram_result_address;
    logic                   result_valid;
    logic                   busy;
    logic                   done;
    logic                   error;

    modport master (
        output cmd_valid, cmd_in_base, cmd_res_base, fifo_empty, end_,
        input  cmd_ready, start, fifo_read_enable, we_rl, valid_address, sram_address,
               sram_result_address, result_valid, busy, done, error
    );

    modport slave (
        input  cmd_valid, cmd_in_base, cmd_res_base, fifo_empty, end_,
        output cmd_ready, start, fifo_read_enable, we_rl, valid_address, sram_address,
               sram_result_address, result_valid, busy, done, error
    );
endinterface

// File: rtl/tpu_matmul_sequencer.sv
// Command-driven sequencer for one weight-load / feed / drain / read-back pass on TOP_tpu.
// Optional macro SEQ_TIMEOUT_EN: bound the DRAIN wait by DRAIN_TIMEOUT cycles and flag error.
module tpu_matmul_sequencer #(
    parameter int ADDRESSSIZE   = 10,
    parameter int MATRIX_SIZE   = 32,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    tpu_matmul_sequencer_if.slave        bus
);

    localparam int CNT_MAX = (MATRIX_SIZE > DRAIN_TIMEOUT) ? MATRIX_SIZE : DRAIN_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_W,
        S_WLOAD,
        S_WLATCH,
        S_FEED,
        S_DRAIN,
        S_READ,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDRESSSIZE-1:0] in_base_q, in_base_d;
    logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   end_prev_q;
    logic                   end_seen_q, end_seen_d;
    logic                   end_rise;

    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   start_q, start_d;
    logic                   fifo_read_enable_q, fifo_read_enable_d;
    logic                   we_rl_q, we_rl_d;
    logic                   valid_address_q, valid_address_d;
    logic [ADDRESSSIZE-1:0] sram_address_q, sram_address_d;
    logic [ADDRESSSIZE-1:0] sram_result_address_q, sram_result_address_d;
    logic                   result_valid_q, result_valid_d;
    logic                   done_q, done_d;
`ifdef SEQ_TIMEOUT_EN
    logic                   error_q, error_d;
`endif

    assign end_rise = bus.end_ & ~end_prev_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d    = state_q;
        in_base_d  = in_base_q;
        res_base_d = res_base_q;
        cnt_d      = cnt_q;
        end_seen_d = end_seen_q;
`ifdef SEQ_TIMEOUT_EN
        error_d    = error_q;
`endif

        // An end_ edge anywhere after the weight pop is remembered, so an early finish is not lost.
        if (state_q != S_IDLE && state_q != S_WAIT_W && end_rise) begin
            end_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    in_base_d  = bus.cmd_in_base;
                    res_base_d = bus.cmd_res_base;
                    end_seen_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    error_d    = 1'b0;
`endif
                    state_d    = bus.fifo_empty ? S_WAIT_W : S_WLOAD;
                end
            end
            S_WAIT_W: begin
                if (!bus.fifo_empty) begin
                    state_d = S_WLOAD;
                end
            end
            S_WLOAD: begin
                state_d = S_WLATCH;
            end
            S_WLATCH: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(MATRIX_SIZE - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (end_seen_q || end_rise) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_READ: begin
                if (cnt_q == CNT_W'(MATRIX_SIZE - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins line up with the state.
        cmd_ready_d           = (state_d == S_IDLE);
        busy_d                = (state_d != S_IDLE);
        start_d               = (state_d != S_IDLE) && (state_d != S_WAIT_W);
        fifo_read_enable_d    = (state_d == S_WLOAD) || (state_d == S_WLATCH);
        we_rl_d               = (state_d == S_WLATCH);
        valid_address_d       = (state_d == S_FEED);
        sram_address_d        = (state_d == S_FEED) ? in_base_d + ADDRESSSIZE'(cnt_d) : '0;
        sram_result_address_d = (state_d == S_READ) ? res_base_d + ADDRESSSIZE'(cnt_d) : '0;
        result_valid_d        = (state_q == S_READ);
        done_d                = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q               <= S_IDLE;
            in_base_q             <= '0;
            res_base_q            <= '0;
            cnt_q                 <= '0;
            end_prev_q            <= 1'b0;
            end_seen_q            <= 1'b0;
            cmd_ready_q           <= 1'b1;
            busy_q                <= 1'b0;
            start_q               <= 1'b0;
            fifo_read_enable_q    <= 1'b0;
            we_rl_q               <= 1'b0;
            valid_address_q       <= 1'b0;
            sram_address_q        <= '0;
            sram_result_address_q <= '0;
            result_valid_q        <= 1'b0;
            done_q                <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            error_q               <= 1'b0;
`endif
        end else begin
            state_q               <= state_d;
            in_base_q             <= in_base_d;
            res_base_q            <= res_base_d;
            cnt_q                 <= cnt_d;
            end_prev_q            <= bus.end_;
            end_seen_q            <= end_seen_d;
            cmd_ready_q           <= cmd_ready_d;
            busy_q                <= busy_d;
            start_q               <= start_d;
            fifo_read_enable_q    <= fifo_read_enable_d;
            we_rl_q               <= we_rl_d;
            valid_address_q       <= valid_address_d;
            sram_address_q        <= sram_address_d;
            sram_result_address_q <= sram_result_address_d;
            result_valid_q        <= result_valid_d;
            done_q                <= done_d;
`ifdef SEQ_TIMEOUT_EN
            error_q               <= error_d;
`endif
        end
    end

    assign bus.cmd_ready           = cmd_ready_q;
    assign bus.busy                = busy_q;
    assign bus.start               = start_q;
    assign bus.fifo_read_enable    = fifo_read_enable_q;
    assign bus.we_rl               = we_rl_q;
    assign bus.valid_address       = valid_address_q;
    assign bus.sram_address        = sram_address_q;
    assign bus.sram_result_address = sram_result_address_q;
    assign bus.result_valid        = result_valid_q;
    assign bus.done                = done_q;
`ifdef SEQ_TIMEOUT_EN
    assign bus.error               = error_q;
`else
    assign bus.error               = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Directed bench for tpu_matmul_sequencer: table of command scenarios plus hand-written
// WAIT_W, drain-wait/timeout and mid-FEED reset sequences. Outputs sampled on falling edges.
module tb_tpu_matmul_sequencer;

    localparam int AW = 10;
    localparam int MS = 32;
    localparam int DT = 16;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    tpu_matmul_sequencer_if #(.ADDRESSSIZE(AW)) bus ();

    tpu_matmul_sequencer #(
        .ADDRESSSIZE  (AW),
        .MATRIX_SIZE  (MS),
        .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [AW-1:0] in_base;
        logic [AW-1:0] res_base;
        int            end_at;     // cycle (accept = 0) in which end_ is high for one cycle
        int            read_first; // first READ cycle
        int            done_at;    // DONE cycle
        logic [AW-1:0] addr_last;
        logic [AW-1:0] res_last;
    } scen_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_start"}, 32'(bus.start), 0);
        check({tag, "_fifo_re"}, 32'(bus.fifo_read_enable), 0);
        check({tag, "_we_rl"}, 32'(bus.we_rl), 0);
        check({tag, "_valid_addr"}, 32'(bus.valid_address), 0);
        check({tag, "_sram_addr"}, 32'(bus.sram_address), 0);
        check({tag, "_res_addr"}, 32'(bus.sram_result_address), 0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_error"}, 32'(bus.error), 0);
    endtask

    // Called at a falling edge with the DUT idle; runs one full command and checks it.
    task automatic run_cmd(input string tag, input scen_t s);
        int fre_n = 0, fre_bad = 0, we_n = 0, we_c = -1;
        int va_n = 0, va_first = -1, addr_bad = 0;
        int rd_bad = 0, zero_bad = 0, rv_n = 0, rv_first = -1;
        int done_n = 0, done_c = -1, ctl_bad = 0, err_bad = 0;
        logic [AW-1:0] va_first_v = '0, va_last_v = '0, rd_first_v = '0, rd_last_v = '0;
        logic [AW-1:0] exp_a;

        check({tag, "_ready_c0"}, 32'(bus.cmd_ready), 1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_in_base  = s.in_base;
        bus.cmd_res_base = s.res_base;
        bus.end_         = (s.end_at == 0);
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            // A second command mid-run must be ignored.
            bus.cmd_valid    = (c == 10);
            bus.cmd_in_base  = 10'd500;
            bus.cmd_res_base = 10'd600;
            bus.end_         = (c == s.end_at);
            if (bus.fifo_read_enable) begin
                fre_n++;
                if (c != 1 && c != 2) fre_bad++;
            end
            if (bus.we_rl) begin
                we_n++;
                we_c = c;
            end
            if (bus.valid_address) begin
                exp_a = s.in_base + AW'(va_n);
                if (bus.sram_address !== exp_a) addr_bad++;
                if (va_n == 0) begin
                    va_first   = c;
                    va_first_v = bus.sram_address;
                end
                va_last_v = bus.sram_address;
                va_n++;
            end else if (bus.sram_address !== '0) begin
                zero_bad++;
            end
            if (c >= s.read_first && c < s.read_first + MS) begin
                exp_a = s.res_base + AW'(c - s.read_first);
                if (bus.sram_result_address !== exp_a) rd_bad++;
                if (c == s.read_first) rd_first_v = bus.sram_result_address;
                rd_last_v = bus.sram_result_address;
            end else if (bus.sram_result_address !== '0) begin
                zero_bad++;
            end
            if (bus.result_valid) begin
                if (rv_n == 0) rv_first = c;
                rv_n++;
            end
            if (bus.error !== 1'b0) err_bad++;
            if (bus.done) begin
                done_n++;
                done_c = c;
            end
            if (done_n > 0 && c == done_c + 1) begin
                check({tag, "_post_ready"}, 32'(bus.cmd_ready), 1);
                check({tag, "_post_busy"}, 32'(bus.busy), 0);
                check({tag, "_post_start"}, 32'(bus.start), 0);
                break;
            end
            if (bus.start !== 1'b1 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) ctl_bad++;
        end
        bus.cmd_valid = 1'b0;
        bus.end_      = 1'b0;
        check({tag, "_fre_cycles"}, 32'(fre_n), 2);
        check({tag, "_fre_outside_1_2"}, 32'(fre_bad), 0);
        check({tag, "_we_rl_count"}, 32'(we_n), 1);
        check({tag, "_we_rl_cycle"}, 32'(we_c), 2);
        check({tag, "_feed_rows"}, 32'(va_n), MS);
        check({tag, "_feed_first_cycle"}, 32'(va_first), 3);
        check({tag, "_feed_first_addr"}, 32'(va_first_v), 32'(s.in_base));
        check({tag, "_feed_last_addr"}, 32'(va_last_v), 32'(s.addr_last));
        check({tag, "_feed_addr_errs"}, 32'(addr_bad), 0);
        check({tag, "_read_first_addr"}, 32'(rd_first_v), 32'(s.res_base));
        check({tag, "_read_last_addr"}, 32'(rd_last_v), 32'(s.res_last));
        check({tag, "_read_addr_errs"}, 32'(rd_bad), 0);
        check({tag, "_idle_addr_nonzero"}, 32'(zero_bad), 0);
        check({tag, "_result_valid_count"}, 32'(rv_n), MS);
        check({tag, "_result_valid_first"}, 32'(rv_first), 32'(s.read_first + 1));
        check({tag, "_done_count"}, 32'(done_n), 1);
        check({tag, "_done_cycle"}, 32'(done_c), 32'(s.done_at));
        check({tag, "_start_busy_ready_errs"}, 32'(ctl_bad), 0);
        check({tag, "_error_set"}, 32'(err_bad), 0);
    endtask

    scen_t scen [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // FEED 3..34, DRAIN from 35; READ is 32 cycles, done the cycle after.
        scen[0] = '{in_base: 10'd0,    res_base: 10'd0,    end_at: 44, read_first: 45, done_at: 77,
                    addr_last: 10'd31,  res_last: 10'd31};
        scen[1] = '{in_base: 10'd1020, res_base: 10'd5,    end_at: 35, read_first: 36, done_at: 68,
                    addr_last: 10'd27,  res_last: 10'd36};
        scen[2] = '{in_base: 10'd100,  res_base: 10'd1000, end_at: 23, read_first: 36, done_at: 68,
                    addr_last: 10'd131, res_last: 10'd7};
        scen[3] = '{in_base: 10'd7,    res_base: 10'd1023, end_at: 2,  read_first: 36, done_at: 68,
                    addr_last: 10'd38,  res_last: 10'd30};

        rstn             = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_in_base  = '0;
        bus.cmd_res_base = '0;
        bus.fifo_empty   = 1'b0;
        bus.end_         = 1'b0;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_cmd($sformatf("scen%0d", i), scen[i]);
            @(negedge clk);
        end

        // Weight FIFO empty for cycles 0..4, falls in cycle 5: WLOAD in 6, WLATCH 7, FEED 8.
        begin
            int fre_early = 0, start_early = 0, done_c = -1;
            bus.fifo_empty   = 1'b1;
            bus.cmd_valid    = 1'b1;
            bus.cmd_in_base  = 10'd40;
            bus.cmd_res_base = 10'd0;
            for (int c = 1; c < 150; c++) begin
                @(negedge clk);
                bus.cmd_valid  = 1'b0;
                bus.fifo_empty = (c < 5);
                bus.end_       = (c == 12);
                if (c <= 5 && bus.fifo_read_enable) fre_early++;
                if (c <= 5 && bus.start) start_early++;
                if (c == 3) check("waitw_busy", 32'(bus.busy), 1);
                if (c == 6) begin
                    check("waitw_wload_fre", 32'(bus.fifo_read_enable), 1);
                    check("waitw_wload_we", 32'(bus.we_rl), 0);
                end
                if (c == 7) check("waitw_wlatch_we", 32'(bus.we_rl), 1);
                if (c == 8) begin
                    check("waitw_feed_valid", 32'(bus.valid_address), 1);
                    check("waitw_feed_addr", 32'(bus.sram_address), 40);
                end
                if (bus.done) done_c = c;
                if (done_c > 0 && c == done_c + 1) break;
            end
            bus.end_ = 1'b0;
            check("waitw_fre_while_empty", 32'(fre_early), 0);
            check("waitw_start_while_empty", 32'(start_early), 0);
            // FEED 8..39, DRAIN 40 (end_ already seen), READ 41..72, DONE 73.
            check("waitw_done_cycle", 32'(done_c), 73);
        end

`ifdef SEQ_TIMEOUT_EN
        // end_ never rises: DRAIN 35..50, DONE 51 with error, no READ.
        begin
            int rv_n = 0, done_c = -1;
            logic err_at_done = 1'b0;
            bus.cmd_valid = 1'b1;
            bus.cmd_in_base = 10'd3;
            for (int c = 1; c < 150; c++) begin
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                if (bus.result_valid) rv_n++;
                if (bus.done && done_c < 0) begin
                    done_c = c;
                    err_at_done = bus.error;
                end
                if (done_c > 0 && c == done_c + 2) break;
            end
            check("timeout_done_cycle", 32'(done_c), 51);
            check("timeout_error_at_done", 32'(err_at_done), 1);
            check("timeout_result_valid", 32'(rv_n), 0);
            check("timeout_error_sticky", 32'(bus.error), 1);
            check("timeout_idle_ready", 32'(bus.cmd_ready), 1);
        end
        // The next command clears error (run_cmd requires error low throughout).
        run_cmd("after_timeout", scen[1]);
        @(negedge clk);
`else
        // Without the timeout DRAIN waits: end_ in cycle 95 gives READ 96..127, DONE 128.
        begin
            int done_c = -1, err_n = 0;
            bus.cmd_valid = 1'b1;
            bus.cmd_in_base = 10'd3;
            for (int c = 1; c < 200; c++) begin
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                bus.end_ = (c == 95);
                if (bus.error) err_n++;
                if (c == 94) check("longdrain_busy", 32'(bus.busy), 1);
                if (bus.done && done_c < 0) done_c = c;
                if (done_c > 0 && c == done_c + 1) break;
            end
            bus.end_ = 1'b0;
            check("longdrain_done_cycle", 32'(done_c), 128);
            check("longdrain_error", 32'(err_n), 0);
        end
`endif

        // Reset during FEED row 5 (cycle 8), asserted between clock edges.
        bus.cmd_valid   = 1'b1;
        bus.cmd_in_base = 10'd200;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        check("midreset_feed_valid", 32'(bus.valid_address), 1);
        check("midreset_feed_addr", 32'(bus.sram_address), 205);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_cmd("after_reset", scen[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
